// File: rtl/dca_refill_ctrl.sv
// Data-cache miss sequencer: on a load miss, fetches the line, fills the cache, then requests a replay.
// Latency: detect + 1 request + LINE_WIDTH beats + fill + replay. Request is held until accepted; beats wait indefinitely.
module dca_refill_ctrl #(
    parameter int LINE_WIDTH = 2,
    parameter int REG_WIDTH  = 32,
    parameter int PA_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_req_valid,
    input  logic                            i_is_load,
    input  logic                            i_hit_cache,
    input  logic                            i_hit_stb,
    input  logic [PA_WIDTH-1:0]             i_addr,
    output logic                            o_stall,
    output logic                            o_mem_req_valid,
    input  logic                            i_mem_req_ready,
    output logic [PA_WIDTH-1:0]             o_mem_addr,
    input  logic                            i_mem_rsp_valid,
    input  logic [REG_WIDTH-1:0]            i_mem_rsp_data,
    input  logic                            i_mem_rsp_err,
    output logic                            o_fill_valid,
    output logic [PA_WIDTH-1:0]             o_fill_addr,
    output logic [LINE_WIDTH*REG_WIDTH-1:0] o_fill_line,
    output logic                            o_replay,
    output logic                            o_exeption
);
    localparam int OFF = $clog2(LINE_WIDTH) + 2;
    localparam int CW  = $clog2(LINE_WIDTH);
    localparam logic [PA_WIDTH-1:0] LINE_MASK = {{(PA_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};
    localparam logic [CW-1:0]       LAST_BEAT = CW'(LINE_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_BEATS  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_REPLAY = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]                      state;
    logic [CW-1:0]                   cnt;
    logic                            err_q;
    logic [PA_WIDTH-1:0]             line_addr;
    logic [LINE_WIDTH*REG_WIDTH-1:0] line_buf;
    logic                            miss;

    assign miss = i_req_valid & i_is_load & ~i_hit_cache & ~i_hit_stb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            line_addr <= '0;
            line_buf  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        line_addr <= i_addr & LINE_MASK;
                        cnt       <= '0;
                        err_q     <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_req_ready) state <= S_BEATS;
                end
                S_BEATS: begin
                    if (i_mem_rsp_valid) begin
                        line_buf[cnt*REG_WIDTH +: REG_WIDTH] <= i_mem_rsp_data;
                        err_q <= err_q | i_mem_rsp_err;
                        cnt   <= cnt + CW'(1);
                        // Error on any beat, including the last one, diverts to FAULT.
                        if (cnt == LAST_BEAT)
                            state <= (err_q | i_mem_rsp_err) ? S_FAULT : S_FILL;
                    end
                end
                S_FILL:   state <= S_REPLAY;
                S_REPLAY: state <= S_IDLE;
                S_FAULT:  state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Stall is combinational in IDLE so the missing load is frozen on the detect cycle.
    assign o_stall         = rst & ((state == S_IDLE) ? miss : (state != S_REPLAY));
    assign o_mem_req_valid = (state == S_REQ);
    assign o_mem_addr      = line_addr;
    assign o_fill_valid    = (state == S_FILL);
    assign o_fill_addr     = line_addr;
    assign o_fill_line     = line_buf;
    assign o_replay        = (state == S_REPLAY);
    assign o_exeption      = (state == S_FAULT);
endmodule

// File: tb/tb_dca_refill_ctrl.sv
// Randomized bench for dca_refill_ctrl: a transaction-level model predicts request, fill data, fault and replay timing.
module tb_dca_refill_ctrl;
    localparam int LW = 2;
    localparam int RW = 32;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_req_valid, i_is_load, i_hit_cache, i_hit_stb;
    logic [AW-1:0]  i_addr;
    logic           o_stall, o_mem_req_valid, i_mem_req_ready;
    logic [AW-1:0]  o_mem_addr;
    logic           i_mem_rsp_valid;
    logic [RW-1:0]  i_mem_rsp_data;
    logic           i_mem_rsp_err;
    logic           o_fill_valid;
    logic [AW-1:0]  o_fill_addr;
    logic [LW*RW-1:0] o_fill_line;
    logic           o_replay, o_exeption;

    int n_cmp = 0;
    int n_bad = 0;
    int req_cnt = 0;

    dca_refill_ctrl #(.LINE_WIDTH(LW), .REG_WIDTH(RW), .PA_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_is_load(i_is_load),
        .i_hit_cache(i_hit_cache), .i_hit_stb(i_hit_stb), .i_addr(i_addr),
        .o_stall(o_stall), .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready), .o_mem_addr(o_mem_addr),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
        .i_mem_rsp_err(i_mem_rsp_err), .o_fill_valid(o_fill_valid),
        .o_fill_addr(o_fill_addr), .o_fill_line(o_fill_line),
        .o_replay(o_replay), .o_exeption(o_exeption)
    );

    always #5 clk = ~clk;

    // Counts accepted memory requests independently of the sequenced checks.
    always @(posedge clk)
        if (rst && o_mem_req_valid && i_mem_req_ready) req_cnt <= req_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid = 0; i_is_load = 0; i_hit_cache = 0; i_hit_stb = 0;
        i_addr = '0; i_mem_req_ready = 0;
        i_mem_rsp_valid = 0; i_mem_rsp_data = '0; i_mem_rsp_err = 0;
    endtask

    // One pipeline access followed, if it misses, by the complete refill handshake.
    task automatic do_access(input bit ld, input bit hc, input bit hs, input logic [AW-1:0] addr,
                             input int rdy_dly, input int gap_max,
                             input logic [RW-1:0] d0, input logic [RW-1:0] d1,
                             input bit e0, input bit e1, input bit replay_miss);
        logic [AW-1:0]    line;
        logic [LW*RW-1:0] exp_line;
        logic [RW-1:0]    dat [LW];
        bit               err [LW];
        bit               miss_exp, any_err;
        int               req0;
        dat[0] = d0; dat[1] = d1; err[0] = e0; err[1] = e1;
        line = addr & ~((AW'(1) << ($clog2(LW) + 2)) - 1);
        miss_exp = ld && !hc && !hs;
        any_err = e0 || e1;
        req0 = req_cnt;

        i_req_valid = 1; i_is_load = ld; i_hit_cache = hc; i_hit_stb = hs; i_addr = addr;
        i_mem_rsp_valid = 1'($urandom_range(0, 1));
        i_mem_rsp_data = $urandom; i_mem_rsp_err = 0;
        #1;
        check("detect_stall", 64'(o_stall), 64'(miss_exp));
        check("detect_noreq", 64'(o_mem_req_valid), 64'd0);
        @(negedge clk);
        idle_inputs();
        if (!miss_exp) begin
            #1;
            check("nomiss_noreq", 64'(o_mem_req_valid), 64'd0);
            check("nomiss_stall", 64'(o_stall), 64'd0);
            return;
        end

        for (int i = 0; i < rdy_dly; i++) begin
            i_mem_rsp_valid = 1'($urandom_range(0, 1));
            i_mem_rsp_data = $urandom;
            #1;
            check("req_hold_vld", 64'(o_mem_req_valid), 64'd1);
            check("req_hold_addr", 64'(o_mem_addr), 64'(line));
            check("req_hold_stall", 64'(o_stall), 64'd1);
            @(negedge clk);
        end
        i_mem_req_ready = 1; i_mem_rsp_valid = 0;
        #1;
        check("req_vld", 64'(o_mem_req_valid), 64'd1);
        check("req_addr", 64'(o_mem_addr), 64'(line));
        @(negedge clk);
        i_mem_req_ready = 1'($urandom_range(0, 1));

        for (int k = 0; k < LW; k++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int j = 0; j < g; j++) begin
                i_mem_rsp_valid = 0; i_mem_rsp_data = $urandom; i_mem_rsp_err = 1'($urandom_range(0, 1));
                #1;
                check("gap_stall", 64'(o_stall), 64'd1);
                check("gap_nofill", 64'(o_fill_valid), 64'd0);
                @(negedge clk);
            end
            i_mem_rsp_valid = 1; i_mem_rsp_data = dat[k]; i_mem_rsp_err = err[k];
            #1;
            check("beat_stall", 64'(o_stall), 64'd1);
            check("beat_noreq", 64'(o_mem_req_valid), 64'd0);
            @(negedge clk);
            idle_inputs();
        end

        for (int k = 0; k < LW; k++) exp_line[k*RW +: RW] = dat[k];
        #1;
        if (any_err) begin
            check("fault_exc", 64'(o_exeption), 64'd1);
            check("fault_nofill", 64'(o_fill_valid), 64'd0);
            check("fault_norep", 64'(o_replay), 64'd0);
            check("fault_stall", 64'(o_stall), 64'd1);
            @(negedge clk);
            #1;
            check("post_fault_exc", 64'(o_exeption), 64'd0);
            check("post_fault_nofill", 64'(o_fill_valid), 64'd0);
            check("post_fault_stall", 64'(o_stall), 64'd0);
            check("post_fault_idle", 64'(o_mem_req_valid), 64'd0);
        end else begin
            check("fill_vld", 64'(o_fill_valid), 64'd1);
            check("fill_addr", 64'(o_fill_addr), 64'(line));
            check("fill_line", 64'(o_fill_line), 64'(exp_line));
            check("fill_stall", 64'(o_stall), 64'd1);
            check("fill_norep", 64'(o_replay), 64'd0);
            @(negedge clk);
            if (replay_miss) begin
                i_req_valid = 1; i_is_load = 1; i_addr = $urandom;
            end
            #1;
            check("replay", 64'(o_replay), 64'd1);
            check("replay_stall", 64'(o_stall), 64'd0);
            check("replay_nofill", 64'(o_fill_valid), 64'd0);
            @(negedge clk);
            idle_inputs();
            #1;
            check("post_replay", 64'(o_replay), 64'd0);
            check("post_replay_stall", 64'(o_stall), 64'd0);
            check("post_replay_idle", 64'(o_mem_req_valid), 64'd0);
        end
        check("one_request", 64'(req_cnt - req0), 64'd1);
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_req", 64'(o_mem_req_valid), 64'd0);
        check("rst_addr", 64'(o_mem_addr), 64'd0);
        check("rst_fill", 64'(o_fill_valid), 64'd0);
        check("rst_line", 64'(o_fill_line), 64'd0);
        check("rst_rep", 64'(o_replay), 64'd0);
        check("rst_exc", 64'(o_exeption), 64'd0);
        rst = 1;
        @(negedge clk);

        do_access(1, 0, 0, 32'h14, 0, 0, 32'hAAAA0001, 32'hBBBB0002, 0, 0, 0);
        do_access(1, 0, 0, 32'h1234_5678, 3, 0, 32'h1111_2222, 32'h3333_4444, 0, 0, 0);
        do_access(1, 0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        do_access(1, 1, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0);
        do_access(0, 0, 0, 32'h50, 0, 0, 0, 0, 0, 0, 0);
        do_access(1, 0, 0, 32'h88, 0, 0, 32'hDEAD_0000, 32'hBEEF_0001, 1, 0, 0);
        do_access(1, 0, 0, 32'hC4, 1, 2, 32'h0000_00C0, 32'h0000_00C4, 0, 0, 1);

        // Reset lands after the first beat of a refill.
        i_req_valid = 1; i_is_load = 1; i_addr = 32'h200;
        @(negedge clk);
        idle_inputs(); i_mem_req_ready = 1;
        @(negedge clk);
        i_mem_req_ready = 0; i_mem_rsp_valid = 1; i_mem_rsp_data = 32'h5555_5555;
        @(negedge clk);
        idle_inputs();
        rst = 0;
        i_req_valid = 1; i_is_load = 1; i_addr = 32'h300;
        @(negedge clk);
        #1;
        check("midrst_stall", 64'(o_stall), 64'd0);
        check("midrst_req", 64'(o_mem_req_valid), 64'd0);
        check("midrst_addr", 64'(o_mem_addr), 64'd0);
        check("midrst_fill", 64'(o_fill_valid), 64'd0);
        check("midrst_faddr", 64'(o_fill_addr), 64'd0);
        check("midrst_line", 64'(o_fill_line), 64'd0);
        check("midrst_rep", 64'(o_replay), 64'd0);
        check("midrst_exc", 64'(o_exeption), 64'd0);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        do_access(1, 0, 0, 32'h3A8, 0, 0, 32'h7777_0000, 32'h7777_0004, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            do_access(kind != 0, kind == 1, kind == 2, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom, $urandom,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      1'($urandom_range(0, 1)));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
